// File: rtl/i2c_target_if.sv
// i2c_target_if: generator-side I2C lines plus the target's parallel data/strobe signals
interface i2c_target_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic SCL;
    logic SDA_OUT;
    logic SDA_OE;
    logic [ADDR_W-1:0] TGT_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic SDA_IN;
    logic [DATA_W-1:0] WR_DATA;
    logic WR_STB;
    logic RD_STB;
    logic BUSY;
    modport master (
        output SCL, SDA_OUT, SDA_OE, TGT_ADDR, RD_DATA,
        input  SDA_IN, WR_DATA, WR_STB, RD_STB, BUSY
    );
    modport slave (
        input  SCL, SDA_OUT, SDA_OE, TGT_ADDR, RD_DATA,
        output SDA_IN, WR_DATA, WR_STB, RD_STB, BUSY
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target for 7-bit addressing and two-byte read/write transfers
module i2c_target #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input logic CLK,
    input logic RESET,
    i2c_target_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, MST_ACK, WAIT_STOP} state_t;
    state_t state, state_n;
    logic scl_q, sda_q, sda, scl_rise, scl_fall, start, stop;
    logic [3:0] cnt, cnt_n;
    logic idx, idx_n, rnw, rnw_n;
    logic [ADDR_W:0] rx, rx_n;
    logic [DATA_W-1:0] tx, tx_n, wr_data, wr_data_n;
    logic sda_in, sda_in_n, wr_stb, wr_stb_n, rd_stb, rd_stb_n, busy, busy_n;

    assign sda = bus.SDA_OE ? bus.SDA_OUT : 1'b1;
    assign scl_rise = ~scl_q & bus.SCL;
    assign scl_fall = scl_q & ~bus.SCL;
    assign start = scl_q & bus.SCL & sda_q & ~sda;
    assign stop = scl_q & bus.SCL & ~sda_q & sda;
    assign bus.SDA_IN = sda_in;
    assign bus.WR_DATA = wr_data;
    assign bus.WR_STB = wr_stb;
    assign bus.RD_STB = rd_stb;
    assign bus.BUSY = busy;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            idx <= 1'b0;
            rnw <= 1'b0;
            rx <= '0;
            tx <= '0;
            sda_in <= 1'b1;
            wr_data <= '0;
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            busy <= 1'b0;
        end else begin
            scl_q <= bus.SCL;
            sda_q <= sda;
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            rnw <= rnw_n;
            rx <= rx_n;
            tx <= tx_n;
            sda_in <= sda_in_n;
            wr_data <= wr_data_n;
            wr_stb <= wr_stb_n;
            rd_stb <= rd_stb_n;
            busy <= busy_n;
        end
    end

    // Receive states count SCL rises; read states count bits already driven onto SDA_IN.
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        idx_n = idx;
        rnw_n = rnw;
        rx_n = rx;
        tx_n = tx;
        sda_in_n = sda_in;
        wr_data_n = wr_data;
        wr_stb_n = 1'b0;
        rd_stb_n = 1'b0;
        busy_n = busy;
        if (stop) begin
            state_n = IDLE;
            sda_in_n = 1'b1;
            busy_n = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            cnt_n = '0;
            idx_n = 1'b0;
        end else begin
            case (state)
                ADDR, WR_BYTE: begin
                    if (scl_rise) begin
                        rx_n = {rx[ADDR_W-1:0], sda};
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8 && state == WR_BYTE) begin
                        sda_in_n = 1'b0;
                        state_n = WR_ACK;
                        wr_data_n = idx ? {wr_data[DATA_W-1:8], rx} : {rx, wr_data[7:0]};
                    end else if (scl_fall && cnt == 4'd8) begin
                        state_n = rx[ADDR_W:1] == bus.TGT_ADDR ? ADDR_ACK : WAIT_STOP;
                        if (rx[ADDR_W:1] == bus.TGT_ADDR) begin
                            sda_in_n = 1'b0;
                            busy_n = 1'b1;
                            rnw_n = rx[0];
                            rd_stb_n = rx[0];
                            tx_n = rx[0] ? bus.RD_DATA : tx;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        state_n = rnw ? RD_BYTE : WR_BYTE;
                        sda_in_n = rnw ? tx[DATA_W-1] : 1'b1;
                        tx_n = rnw ? {tx[DATA_W-2:0], 1'b0} : tx;
                        cnt_n = rnw ? 4'd1 : 4'd0;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_in_n = 1'b1;
                        cnt_n = '0;
                        idx_n = 1'b1;
                        wr_stb_n = idx;
                        state_n = idx ? WAIT_STOP : WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall && cnt == 4'd8) begin
                        sda_in_n = 1'b1;
                        state_n = MST_ACK;
                    end else if (scl_fall) begin
                        sda_in_n = tx[DATA_W-1];
                        tx_n = {tx[DATA_W-2:0], 1'b0};
                        cnt_n = cnt + 4'd1;
                    end
                end
                MST_ACK: begin
                    if (scl_rise) begin
                        cnt_n = '0;
                        idx_n = 1'b1;
                        state_n = (sda || idx) ? WAIT_STOP : RD_BYTE;
                    end
                end
                WAIT_STOP: sda_in_n = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
